// File: rtl/dmem_arbiter.sv
// Two-port (CPU / debug) data-memory arbiter: round-robin grant, one transaction
// in flight, per-transaction ack timeout and a saturating CPU stall counter.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        a_req_i,
  input  logic        a_we_i,
  input  logic [31:0] a_addr_i,
  input  logic [31:0] a_wdata_i,
  output logic [31:0] a_rdata_o,
  output logic        a_done_o,
  output logic        a_err_o,
  output logic        a_stall_o,
  input  logic        b_req_i,
  input  logic        b_we_i,
  input  logic [31:0] b_addr_i,
  input  logic [31:0] b_wdata_i,
  output logic [31:0] b_rdata_o,
  output logic        b_done_o,
  output logic        b_err_o,
  output logic        m_en_o,
  output logic        m_we_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  input  logic [31:0] m_rdata_i,
  input  logic        m_ack_i,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic        win_q, win_d;     // 0 = port A, 1 = port B
  logic        rr_q, rr_d;       // port granted most recently
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        err_q, err_d;
  logic [31:0] a_rdata_q, a_rdata_d;
  logic [31:0] b_rdata_q, b_rdata_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        grant_b;

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    rr_d        = rr_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wcnt_d      = wcnt_q;
    err_d       = err_q;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    grant_b     = b_req_i && (!a_req_i || !rr_q);
    unique case (state_q)
      S_IDLE: begin
        if (start_i && (a_req_i || b_req_i)) begin
          win_d   = grant_b;
          rr_d    = grant_b;
          we_d    = grant_b ? b_we_i    : a_we_i;
          addr_d  = grant_b ? b_addr_i  : a_addr_i;
          wdata_d = grant_b ? b_wdata_i : a_wdata_i;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wcnt_d  = '0;
        err_d   = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (m_ack_i) begin
          if (!we_q) begin
            if (win_q) b_rdata_d = m_rdata_i;
            else       a_rdata_d = m_rdata_i;
          end
          state_d = S_DONE;
        end else if (wcnt_q == 8'(MAX_WAIT - 1)) begin
          // last permitted wait cycle without ack: abort so done lands MAX_WAIT after entry
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (a_stall_o && start_i && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      win_q       <= 1'b0;
      rr_q        <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wcnt_q      <= '0;
      err_q       <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      rr_q        <= rr_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wcnt_q      <= wcnt_d;
      err_q       <= err_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign m_en_o      = (state_q == S_ISSUE);
  assign m_we_o      = we_q;
  assign m_addr_o    = addr_q;
  assign m_wdata_o   = wdata_q;
  assign a_done_o    = (state_q == S_DONE) && !win_q;
  assign b_done_o    = (state_q == S_DONE) && win_q;
  assign a_err_o     = a_done_o && err_q;
  assign b_err_o     = b_done_o && err_q;
  assign a_rdata_o   = a_rdata_q;
  assign b_rdata_o   = b_rdata_q;
  assign a_stall_o   = a_req_i && !a_done_o;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a transaction-level model predicts grant order,
// memory commands, completion cycles and read data; a monitor pops and compares.
module tb_dmem_arbiter;

  localparam int unsigned MW = 8;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i;
  logic        a_req_i, a_we_i, b_req_i, b_we_i;
  logic [31:0] a_addr_i, a_wdata_i, b_addr_i, b_wdata_i;
  logic [31:0] a_rdata_o, b_rdata_o, m_addr_o, m_wdata_o, m_rdata_i, stall_cnt_o;
  logic        a_done_o, a_err_o, a_stall_o, b_done_o, b_err_o;
  logic        m_en_o, m_we_o, m_ack_i;

  dmem_arbiter #(.MAX_WAIT(MW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .a_req_i(a_req_i), .a_we_i(a_we_i), .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i),
    .a_rdata_o(a_rdata_o), .a_done_o(a_done_o), .a_err_o(a_err_o), .a_stall_o(a_stall_o),
    .b_req_i(b_req_i), .b_we_i(b_we_i), .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i),
    .b_rdata_o(b_rdata_o), .b_done_o(b_done_o), .b_err_o(b_err_o),
    .m_en_o(m_en_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_rdata_i(m_rdata_i), .m_ack_i(m_ack_i), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; int cyc; } cmd_t;
  typedef struct { logic port; logic err; logic [31:0] rdata; int cyc; } rsp_t;
  typedef struct { int k; logic [31:0] data; } mem_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  mem_t mem_q[$];

  int checks = 0;
  int failures = 0;

  // Reference state: last granted port, per-port read data, expected stall count
  bit          last;
  logic [31:0] rd [2];
  int          exp_stall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    failures++;
    $display("FAIL %s cyc=%0d", nm, cyc);
  endtask

  task automatic model_reset();
    last      = 1'b1;
    rd[0]     = '0;
    rd[1]     = '0;
    exp_stall = 0;
  endtask

  task automatic reset_checks();
    chk("rst_m_en", m_en_o, 0);
    chk("rst_m_we", m_we_o, 0);
    chk("rst_m_addr", m_addr_o, 0);
    chk("rst_m_wdata", m_wdata_o, 0);
    chk("rst_a_done", a_done_o, 0);
    chk("rst_b_done", b_done_o, 0);
    chk("rst_a_err", a_err_o, 0);
    chk("rst_b_err", b_err_o, 0);
    chk("rst_a_rdata", a_rdata_o, 0);
    chk("rst_b_rdata", b_rdata_o, 0);
    chk("rst_stall_cnt", stall_cnt_o, 0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    reset_checks();
    rst_i = 1'b0;
    model_reset();
  endtask

  // Memory model: ack k wait-cycles after WAIT entry, or never when k >= MW
  initial begin
    mem_t m;
    m_ack_i   = 1'b0;
    m_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (m_en_o && mem_q.size() > 0) begin
        m = mem_q.pop_front();
        if (m.k < int'(MW)) begin
          repeat (m.k + 1) @(negedge clk_i);
          m_ack_i   = 1'b1;
          m_rdata_i = m.data;
          @(negedge clk_i);
          m_ack_i   = 1'b0;
          m_rdata_i = $urandom;
        end
      end
    end
  end

  initial begin
    cmd_t ce;
    rsp_t re;
    forever begin
      @(negedge clk_i);
      #1;
      if (!rst_i) begin
        chk("a_stall", {31'b0, a_stall_o}, {31'b0, a_req_i & ~a_done_o});
        if (m_en_o) begin
          if (cmd_q.size() == 0) flag("unexpected_m_en");
          else begin
            ce = cmd_q.pop_front();
            chk("m_we", {31'b0, m_we_o}, {31'b0, ce.we});
            chk("m_addr", m_addr_o, ce.addr);
            chk("m_wdata", m_wdata_o, ce.wdata);
            chk("m_en_cycle", cyc, ce.cyc);
          end
        end
        if (a_done_o && b_done_o) flag("both_done");
        else if (a_done_o || b_done_o) begin
          if (rsp_q.size() == 0) flag("unexpected_done");
          else begin
            re = rsp_q.pop_front();
            chk("done_port", {31'b0, b_done_o}, {31'b0, re.port});
            chk("done_cycle", cyc, re.cyc);
            chk("done_err", {31'b0, re.port ? b_err_o : a_err_o}, {31'b0, re.err});
            chk("done_rdata", re.port ? b_rdata_o : a_rdata_o, re.rdata);
          end
        end
        if (a_err_o && !a_done_o) flag("a_err_without_done");
        if (b_err_o && !b_done_o) flag("b_err_without_done");
      end
    end
  end

  task automatic run_scn(input bit ra, rb, awe, bwe,
                         input logic [31:0] aad, awd, bad, bwd,
                         input int ka, kb, input logic [31:0] ad, bd,
                         input bit drop, input int pre_off);
    int n, g, dn, cnt, k;
    bit p, we, er;
    logic [31:0] adr, wd, md;
    @(negedge clk_i);
    a_req_i = ra; a_we_i = awe; a_addr_i = aad; a_wdata_i = awd;
    b_req_i = rb; b_we_i = bwe; b_addr_i = bad; b_wdata_i = bwd;
    start_i = (pre_off == 0);
    if (pre_off > 0) begin
      repeat (pre_off) @(negedge clk_i);
      chk("startlow_stall", stall_cnt_o, 32'(exp_stall));
      start_i = 1'b1;
    end
    n   = cyc;
    g   = n;
    cnt = int'(ra) + int'(rb);
    p   = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      if (i == 0) p = (ra && rb) ? ~last : rb;
      else        p = ~p;
      we  = p ? bwe : awe;
      adr = p ? bad : aad;
      wd  = p ? bwd : awd;
      k   = p ? kb  : ka;
      md  = p ? bd  : ad;
      er  = (k >= int'(MW));
      dn  = er ? g + 2 + int'(MW) : g + 3 + k;
      cmd_q.push_back('{we, adr, wd, g + 1});
      mem_q.push_back('{k, md});
      if (!er && !we) rd[p] = md;
      rsp_q.push_back('{p, er, rd[p], dn});
      if (!p) exp_stall += drop ? 2 : dn - n;
      last = p;
      g = dn + 1;
    end
    for (int guard = 0; guard < 2 * (int'(MW) + 6) + 4; guard++) begin
      @(negedge clk_i);
      if (drop && cyc == n + 2) start_i = 1'b0;
      if (a_done_o) begin a_req_i = 1'b0; start_i = 1'b1; end
      if (b_done_o) begin b_req_i = 1'b0; start_i = 1'b1; end
      if (!a_req_i && !b_req_i) break;
    end
    if (a_req_i || b_req_i) begin
      flag("done_wait_expired");
      a_req_i = 1'b0; b_req_i = 1'b0; start_i = 1'b1;
    end
    chk("stall_cnt", stall_cnt_o, 32'(exp_stall));
  endtask

  task automatic reset_mid_wait();
    int n;
    @(negedge clk_i);
    a_req_i = 1'b1; a_we_i = 1'b0; a_addr_i = 32'h40; a_wdata_i = $urandom;
    b_req_i = 1'b0; start_i = 1'b1;
    n = cyc;
    cmd_q.push_back('{1'b0, 32'h40, a_wdata_i, n + 1});
    mem_q.push_back('{4, 32'hDEAD_BEEF});
    repeat (3) @(negedge clk_i);
    rst_i   = 1'b1;
    a_req_i = 1'b0;
    @(negedge clk_i);
    reset_checks();
    rst_i = 1'b0;
    model_reset();
    repeat (5) @(negedge clk_i);
    chk("late_ack_a_rdata", a_rdata_o, 0);
    chk("late_ack_stall_cnt", stall_cnt_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; start_i = 1'b1;
    a_req_i = 1'b0; a_we_i = 1'b0; a_addr_i = '0; a_wdata_i = '0;
    b_req_i = 1'b0; b_we_i = 1'b0; b_addr_i = '0; b_wdata_i = '0;
    model_reset();
    repeat (3) @(negedge clk_i);
    reset_checks();
    rst_i = 1'b0;

    // single CPU load, ack on first wait cycle
    run_scn(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h5, 32'h0, 0, 0);
    chk("first_load_stall", stall_cnt_o, 32'd3);
    chk("first_load_rdata", a_rdata_o, 32'h5);

    // ties after reset alternate A, B, A, B ...
    do_reset();
    run_scn(1, 1, 0, 0, 32'h100, 32'h1, 32'h200, 32'h2, 1, 2, 32'hA1, 32'hB1, 0, 0);
    run_scn(1, 1, 0, 0, 32'h104, 32'h3, 32'h204, 32'h4, 0, 0, 32'hA2, 32'hB2, 0, 0);

    // debug store leaves its read data alone
    run_scn(0, 1, 0, 1, 32'h0, 32'h0, 32'h10, 32'h1234, 0, 1, 32'h0, 32'h5555, 0, 0);
    chk("store_b_rdata", b_rdata_o, 32'hB2);

    // load, then timeout keeps previous read data
    run_scn(1, 0, 0, 0, 32'h20, 32'h0, 32'h0, 32'h0, 2, 0, 32'hCAFE_0001, 32'h0, 0, 0);
    run_scn(1, 0, 0, 0, 32'h24, 32'h0, 32'h0, 32'h0, int'(MW), 0, 32'h1111, 32'h0, 0, 0);
    chk("timeout_a_rdata", a_rdata_o, 32'hCAFE_0001);

    reset_mid_wait();

    // held request with start low, then start high
    run_scn(1, 0, 0, 0, 32'h30, 32'h0, 32'h0, 32'h0, 1, 0, 32'h77, 32'h0, 0, 5);
    // start falls mid-transaction
    run_scn(1, 0, 0, 0, 32'h34, 32'h0, 32'h0, 32'h0, 3, 0, 32'h88, 32'h0, 1, 0);

    for (int i = 0; i < 80; i++) begin
      int r, pre;
      bit ra, rb, drop;
      r    = int'($urandom_range(1, 3));
      ra   = r[0];
      rb   = r[1];
      drop = (ra ^ rb) && ($urandom_range(0, 3) == 0);
      pre  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_scn(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom, $urandom, $urandom, $urandom,
              int'($urandom_range(0, MW + 1)), int'($urandom_range(0, MW + 1)),
              $urandom, $urandom, drop, pre);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

    repeat (4) @(negedge clk_i);
    chk("cmd_q_drained", cmd_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
